// File: rtl/i2c_slave.sv
// Single-address I2C target: synchronizes SCL/SDA, detects START/STOP,
// matches a 7-bit address, ACKs written bytes and shifts out read bytes.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       rw
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;

    logic [1:0] r_scl_sync, r_sda_sync;
    logic       r_scl_hist, r_sda_hist;
    logic       r_scl_rise, r_scl_fall, r_start, r_stop;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [7:0] r_tx_sh, w_tx_sh_nxt;
    logic       r_ack, w_ack_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic [7:0] r_rx_data, w_rx_data_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic       r_tx_req, w_tx_req_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_rw, w_rw_nxt;
    logic [7:0] w_byte;

    // Sync regs reset to 1 (idle bus) so leaving reset never fakes a START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every stage one clock apart.
            r_scl_sync <= {r_scl_sync[0], scl_i};
            r_sda_sync <= {r_sda_sync[0], sda_i};
            r_scl_hist <= r_scl_sync[1];
            r_sda_hist <= r_sda_sync[1];
            r_scl_rise <= r_scl_sync[1] & ~r_scl_hist;
            r_scl_fall <= ~r_scl_sync[1] & r_scl_hist;
            r_start    <= r_scl_sync[1] & r_scl_hist & r_sda_hist & ~r_sda_sync[1];
            r_stop     <= r_scl_sync[1] & r_scl_hist & ~r_sda_hist & r_sda_sync[1];
        end
    end

    assign w_byte = {r_shift[6:0], r_sda_hist};

    always_comb begin
        // NOTE: every next-state value gets a default here, so no latches.
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_tx_sh_nxt    = r_tx_sh;
        w_ack_nxt      = r_ack;
        w_sda_oe_nxt   = r_sda_oe;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_tx_req_nxt   = 1'b0;
        w_busy_nxt     = r_busy;
        w_rw_nxt       = r_rw;

        if (r_start) begin
            w_state_nxt  = ADDR;
            w_cnt_nxt    = 3'd0;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_ack_nxt    = 1'b0;
        end else if (r_stop) begin
            w_state_nxt  = IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else begin
            case (r_state)
                ADDR: if (r_scl_rise) begin
                    w_shift_nxt = w_byte;
                    w_cnt_nxt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        if (w_byte[7:1] == SLAVE_ADDR) begin
                            w_rw_nxt     = w_byte[0];
                            w_busy_nxt   = 1'b1;
                            w_tx_req_nxt = w_byte[0];
                            w_ack_nxt    = 1'b0;
                            w_state_nxt  = ADDR_ACK;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                // r_ack marks that the ACK bit is already on the bus.
                ADDR_ACK, WR_ACK: if (r_scl_fall) begin
                    if (!r_ack) begin
                        w_sda_oe_nxt = 1'b1;
                        w_ack_nxt    = 1'b1;
                    end else begin
                        w_ack_nxt = 1'b0;
                        if (r_state == ADDR_ACK && r_rw) begin
                            w_tx_sh_nxt  = {tx_data[6:0], 1'b0};
                            w_sda_oe_nxt = ~tx_data[7];
                            w_cnt_nxt    = 3'd1;
                            w_state_nxt  = RD_DATA;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_cnt_nxt    = 3'd0;
                            w_state_nxt  = WR_DATA;
                        end
                    end
                end
                WR_DATA: if (r_scl_rise) begin
                    w_shift_nxt = w_byte;
                    w_cnt_nxt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_rx_data_nxt  = w_byte;
                        w_rx_valid_nxt = 1'b1;
                        w_ack_nxt      = 1'b0;
                        w_state_nxt    = WR_ACK;
                    end
                end
                // r_cnt counts bits already driven; wrap to 0 means byte done.
                RD_DATA: if (r_scl_fall) begin
                    if (r_cnt == 3'd0) begin
                        w_sda_oe_nxt = 1'b0;
                        w_ack_nxt    = 1'b0;
                        w_state_nxt  = RD_ACK;
                    end else begin
                        w_sda_oe_nxt = ~r_tx_sh[7];
                        w_tx_sh_nxt  = {r_tx_sh[6:0], 1'b0};
                        w_cnt_nxt    = r_cnt + 3'd1;
                    end
                end
                RD_ACK: begin
                    if (r_scl_rise && !r_ack) begin
                        if (!r_sda_hist) begin
                            w_tx_req_nxt = 1'b1;
                            w_ack_nxt    = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else if (r_scl_fall && r_ack) begin
                        w_ack_nxt    = 1'b0;
                        w_tx_sh_nxt  = {tx_data[6:0], 1'b0};
                        w_sda_oe_nxt = ~tx_data[7];
                        w_cnt_nxt    = 3'd1;
                        w_state_nxt  = RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 3'd0;
            r_shift    <= 8'h00;
            r_tx_sh    <= 8'h00;
            r_ack      <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_busy     <= 1'b0;
            r_rw       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_tx_sh    <= w_tx_sh_nxt;
            r_ack      <= w_ack_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_tx_req   <= w_tx_req_nxt;
            r_busy     <= w_busy_nxt;
            r_rw       <= w_rw_nxt;
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = r_tx_req;
    assign busy     = r_busy;
    assign rw       = r_rw;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-level bus master on a wired-AND SDA line.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int Q = 100;  // quarter SCL period in ns (SCL = 40 clk cycles)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic       busy;
    logic       rw;

    int n_checks = 0;
    int n_fail   = 0;
    int rxv_cnt  = 0;
    int txr_cnt  = 0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_m),
        .sda_i    (sda_line),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy),
        .rw       (rw)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid) rxv_cnt <= rxv_cnt + 1;
        if (tx_req)   txr_cnt <= txr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_m = b;
        #(Q);
        scl_m = 1'b1;
        #(Q);
        s = sda_line;
        #(Q);
        scl_m = 1'b0;
        #(Q);
    endtask

    task automatic start_cond();
        sda_m = 1'b1;
        #(Q);
        scl_m = 1'b1;
        #(Q);
        sda_m = 1'b0;
        #(Q);
        scl_m = 1'b0;
        #(Q);
    endtask

    task automatic stop_cond();
        sda_m = 1'b0;
        #(Q);
        scl_m = 1'b1;
        #(Q);
        sda_m = 1'b1;
        #(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_bits(output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s);
            d = {d[6:0], s};
        end
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] d;
        logic [7:0] pat;
        int         rxv0, txr0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_sda_oe",   sda_oe,   1'b0);
        check("rst_rx_data",  rx_data,  8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_tx_req",   tx_req,   1'b0);
        check("rst_busy",     busy,     1'b0);
        check("rst_rw",       rw,       1'b0);

        // Write 0xA5 to 0x50
        start_cond();
        write_byte(8'hA0, ack);
        check("wr_addr_ack", ack, 1'b0);
        check("wr_busy", busy, 1'b1);
        check("wr_rw", rw, 1'b0);
        write_byte(8'hA5, ack);
        check("wr_data_ack", ack, 1'b0);
        check("wr_rx_data", rx_data, 8'hA5);
        check("wr_rx_valid_cnt", rxv_cnt, 1);
        stop_cond();
        check("wr_busy_after_stop", busy, 1'b0);
        check("wr_sda_oe_after_stop", sda_oe, 1'b0);

        // Wrong address 0x51
        start_cond();
        write_byte(8'hA2, ack);
        check("bad_addr_nack", ack, 1'b1);
        check("bad_addr_busy", busy, 1'b0);
        stop_cond();
        check("bad_addr_rx_valid_cnt", rxv_cnt, 1);

        // Read 0x3C then 0xC3, master ACK then NACK
        tx_data = 8'h3C;
        txr0 = txr_cnt;
        start_cond();
        write_byte(8'hA1, ack);
        check("rd_addr_ack", ack, 1'b0);
        check("rd_rw", rw, 1'b1);
        check("rd_tx_req_addr", txr_cnt - txr0, 1);
        read_bits(d);
        check("rd_byte0", d, 8'h3C);
        tx_data = 8'hC3;
        clock_bit(1'b0, s);
        check("rd_tx_req_ack", txr_cnt - txr0, 2);
        read_bits(d);
        check("rd_byte1", d, 8'hC3);
        clock_bit(1'b1, s);
        check("rd_nack_seen", s, 1'b1);
        check("rd_sda_released", sda_oe, 1'b0);
        check("rd_busy_after_nack", busy, 1'b1);
        check("rd_tx_req_total", txr_cnt - txr0, 2);
        stop_cond();
        check("rd_busy_after_stop", busy, 1'b0);

        // Write 0x11, repeated START, read 0x5A
        rxv0 = rxv_cnt;
        start_cond();
        write_byte(8'hA0, ack);
        write_byte(8'h11, ack);
        check("rs_wr_ack", ack, 1'b0);
        check("rs_rx_data", rx_data, 8'h11);
        check("rs_rx_valid_cnt", rxv_cnt - rxv0, 1);
        tx_data = 8'h5A;
        start_cond();
        write_byte(8'hA1, ack);
        check("rs_rd_addr_ack", ack, 1'b0);
        check("rs_rw", rw, 1'b1);
        check("rs_busy", busy, 1'b1);
        read_bits(d);
        check("rs_rd_byte", d, 8'h5A);
        clock_bit(1'b1, s);
        stop_cond();
        check("rs_rx_data_kept", rx_data, 8'h11);

        // STOP after 4 data bits
        rxv0 = rxv_cnt;
        start_cond();
        write_byte(8'hA0, ack);
        pat = 8'hF0;
        for (int i = 7; i >= 4; i--) clock_bit(pat[i], s);
        stop_cond();
        check("part_no_rx_valid", rxv_cnt - rxv0, 0);
        check("part_sda_oe", sda_oe, 1'b0);
        check("part_busy", busy, 1'b0);
        check("part_rx_data_kept", rx_data, 8'h11);

        // Reset while the target is driving the address ACK
        start_cond();
        pat = 8'hA0;
        for (int i = 7; i >= 0; i--) clock_bit(pat[i], s);
        sda_m = 1'b1;
        #(Q);
        check("rst_mid_ack_driven", sda_oe, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_sda_oe", sda_oe, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_rx_data", rx_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        scl_m = 1'b1;
        #(2 * Q);
        scl_m = 1'b0;
        #(Q);
        stop_cond();
        rxv0 = rxv_cnt;
        start_cond();
        write_byte(8'hA0, ack);
        check("post_rst_addr_ack", ack, 1'b0);
        write_byte(8'h7E, ack);
        check("post_rst_data_ack", ack, 1'b0);
        check("post_rst_rx_data", rx_data, 8'h7E);
        check("post_rst_rx_valid_cnt", rxv_cnt - rxv0, 1);
        stop_cond();
        check("post_rst_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Single-address I2C target (slave) for the same bus driven by the team's I2C master block. Samples the open-drain SCL/SDA lines, detects START/STOP, matches a 7-bit address, ACKs and delivers written bytes, and shifts out read bytes supplied by the host logic. No clock stretching, no general call, no 10-bit addressing.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit bus address this target responds to.
- `clk`  in  1  system clock; must be ≥16× SCL frequency.
- `rst`  in  1  asynchronous, active-high reset.
- `scl_i`  in  1  SCL line level (asynchronous to `clk`).
- `sda_i`  in  1  SDA line level (asynchronous to `clk`).
- `sda_oe`  out  1  1 = pull SDA low; 0 = release (pad ties output data to 0).
- `rx_data`  out  8  last byte written by master; holds until next byte.
- `rx_valid`  out  1  one-cycle pulse, `rx_data` updated this cycle.
- `tx_data`  in  8  byte to return on a read.
- `tx_req`  out  1  one-cycle pulse requesting the next `tx_data`.
- `busy`  out  1  high from address match until STOP/START or mismatch.
- `rw`  out  1  R/W bit of current transaction (1 = read); valid while `busy`.

## Operation
- `scl_i`/`sda_i` pass through 2-FF synchronizers plus one history register; edge detection on synchronized values.
- START = SDA falling while SCL high; STOP = SDA rising while SCL high. Both recognized in every state and take priority over bit handling.
- Bits sampled on SCL rising edge, MSB first; `sda_oe` changes only on SCL falling edge (or on STOP/START/reset).
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
  - Any state, START (incl. repeated START) -> ADDR, bit counter = 0, `sda_oe`=0, `busy`=0.
  - Any state, STOP -> IDLE, `sda_oe`=0, `busy`=0.
  - ADDR: shift 8 bits. On 8th rising edge: if [7:1]==`SLAVE_ADDR` latch `rw`, set `busy`, -> ADDR_ACK; else -> IDLE (ignore bus until next START).
  - ADDR_ACK: next SCL fall asserts `sda_oe`; the following SCL fall releases it (write) or drives bit 7 of latched `tx_data` (read). Write -> WR_DATA; read -> RD_DATA. `tx_req` pulses on the 8th address rising edge when `rw`=1.
  - WR_DATA: shift 8 bits; on 8th rising edge load `rx_data`, pulse `rx_valid`, -> WR_ACK. Every write byte is ACKed.
  - WR_ACK: assert `sda_oe` on next fall, release on the following fall, -> WR_DATA.
  - RD_DATA: drive tx shift register MSB on each fall (`sda_oe` = ~bit); after 8th bit, release SDA on fall, -> RD_ACK.
  - RD_ACK: sample SDA on rising edge. ACK (0): pulse `tx_req`, -> RD_DATA, `tx_data` latched at next SCL fall. NACK (1): -> IDLE, SDA released, `busy` stays high until STOP/START.
- Bit counter 3 bits, wraps 7->0 at byte end.

## Timing
- Reset values: `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `busy`=0, `rw`=0, state IDLE.
- Pin change to detected edge: 3 `clk` cycles; `sda_oe` update 1 cycle later (4 cycles from SCL fall pin).
- `rx_valid` asserts 4 cycles after 8th data SCL rising pin edge.
- `tx_data` must be stable from `tx_req` pulse until next SCL falling edge (≥ half SCL period).
- Reset mid-transaction: immediate release of SDA, all outputs to reset values; bus ignored until next START.
- START/STOP mid-byte: partial byte discarded, no `rx_valid`.

## Test plan
- Write addr 0x50+W, data 0xA5, STOP -> ACK on addr and data bits, `rx_data`=0xA5, one `rx_valid`, `busy` low after STOP.
- Addr 0x51+W -> no ACK (SDA stays high at 9th clock), no `rx_valid`, `busy`=0.
- Addr 0x50+R, `tx_data`=0x3C then 0xC3, master ACK then NACK -> bus bits 0x3C, 0xC3; two `tx_req` pulses; SDA released after NACK.
- Write 0x11, repeated START, addr 0x50+R -> `rx_data`=0x11, `rw`=1, read proceeds correctly.
- STOP after 4 bits of a write byte -> no `rx_valid`, state IDLE, `sda_oe`=0.
- Assert `rst` while driving ACK -> `sda_oe`=0 next edge, next full write 0x7E still received correctly.
